// File: rtl/sc_fifo_ext.sv
// Parametrised single-clock FIFO: configurable depth, almost-full/empty thresholds,
// standard or first-word-fall-through read, occupancy count, sync flush, sticky error flags.
module sc_fifo_ext #(
    parameter int unsigned NBITS     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [NBITS-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [NBITS-1:0]       rd_data,
    output logic                   valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [NBITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_udf;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_nxt;

    // Flush blocks both ports so neither moves data nor raises a sticky flag.
    always_comb begin
        w_wr_acc    = wr_en & ~r_full & ~flush;
        w_rd_acc    = rd_en & ~r_empty & ~flush;
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage is not reset; the rst_n gate keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_af    <= (w_count_nxt >= CW'(AF_THRESH));
            r_ae    <= (w_count_nxt <= CW'(AE_THRESH));
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
                if (wr_en && r_full)  r_ovf <= 1'b1;
                if (rd_en && r_empty) r_udf <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [NBITS-1:0] r_rd_data;
            logic             r_valid;

            // Registered read: data and a one-cycle valid pulse follow each accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                    r_valid   <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data = r_rd_data;
            assign valid   = r_valid;
        end else begin : g_fwft
            // Head word is presented directly; rd_en acknowledges it.
            assign valid   = ~r_empty;
            assign rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
        end
    endgenerate

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sc_fifo_ext.sv
// Self-checking bench for sc_fifo_ext: one standard-read and one FWFT instance share stimulus
// and are compared each cycle against a queue-based reference, plus hand-computed vectors.
module tb_sc_fifo_ext;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    wr_data;

    logic [7:0]    rd_s, rd_f;
    logic          valid_s, valid_f, empty_s, empty_f, full_s, full_f;
    logic          af_s, af_f, ae_s, ae_f, ov_s, ov_f, un_s, un_f;
    logic [CW-1:0] count_s, count_f;

    sc_fifo_ext #(.NBITS(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_s), .valid(valid_s), .empty(empty_s), .full(full_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ov_s), .underflow(un_s)
    );

    sc_fifo_ext #(.NBITS(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_f), .valid(valid_f), .empty(empty_f), .full(full_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ov_f), .underflow(un_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: contents as a queue, sticky flags, and the standard-mode read port.
    logic [7:0] q[$];
    bit         m_ov, m_un, m_v0;
    logic [7:0] m_rd0;

    typedef struct {
        bit         f;
        bit         w;
        logic [7:0] d;
        bit         r;
        int         cnt;
        bit         v0;
        logic [7:0] rd0;
        bit         ov;
        bit         un;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov  = 1'b0;
        m_un  = 1'b0;
        m_v0  = 1'b0;
        m_rd0 = 8'h00;
    endtask

    task automatic model_step(input bit f, input bit w, input logic [7:0] d, input bit r);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_v0 = 1'b0;
        end else begin
            if (w && was_full)  m_ov = 1'b1;
            if (r && was_empty) m_un = 1'b1;
            m_v0 = r && !was_empty;
            if (r && !was_empty) m_rd0 = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count_s", int'(count_s), sz);
        chk("count_f", int'(count_f), sz);
        chk("empty_s", int'(empty_s), int'(sz == 0));
        chk("empty_f", int'(empty_f), int'(sz == 0));
        chk("full_s", int'(full_s), int'(sz == DEPTH));
        chk("full_f", int'(full_f), int'(sz == DEPTH));
        chk("afull_s", int'(af_s), int'(sz >= AF));
        chk("afull_f", int'(af_f), int'(sz >= AF));
        chk("aempty_s", int'(ae_s), int'(sz <= AE));
        chk("aempty_f", int'(ae_f), int'(sz <= AE));
        chk("ovf_s", int'(ov_s), int'(m_ov));
        chk("ovf_f", int'(ov_f), int'(m_ov));
        chk("udf_s", int'(un_s), int'(m_un));
        chk("udf_f", int'(un_f), int'(m_un));
        chk("valid_s", int'(valid_s), int'(m_v0));
        chk("rdata_s", int'(rd_s), int'(m_rd0));
        chk("valid_f", int'(valid_f), int'(sz > 0));
        chk("rdata_f", int'(rd_f), (sz > 0) ? int'(q[0]) : 0);
    endtask

    // Apply one cycle of inputs, advance the reference, then compare just after the edge.
    task automatic step(input bit f, input bit w, input logic [7:0] d, input bit r);
        flush   = f;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        model_step(f, w, d, r);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_model();
    endtask

    initial begin
        int rd_idx;
        int wp;
        int rp;

        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty_s), 1);
        chk("rst_aempty", int'(ae_s), 1);
        chk("rst_count", int'(count_s), 0);
        chk("rst_valid_s", int'(valid_s), 0);
        chk("rst_valid_f", int'(valid_f), 0);
        chk("rst_ovf", int'(ov_s), 0);
        chk("rst_udf", int'(un_s), 0);
        chk("rst_rdata", int'(rd_s), 0);
        check_model();
        rst_n = 1'b1;

        // Hand-computed short sequence, standard-read expectations.
        tbl[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hB4, 1'b1, 3, 1'b1, 8'hA1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'hA2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hA3, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hB4, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hB4, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'hC5, 1'b1, 1, 1'b0, 8'hB4, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'hC6, 1'b0, 0, 1'b0, 8'hB4, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'hB4, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'hD7, 1'b0, 1, 1'b0, 8'hB4, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].r);
            chk("tbl_count", int'(count_s), tbl[i].cnt);
            chk("tbl_valid", int'(valid_s), int'(tbl[i].v0));
            chk("tbl_rdata", int'(rd_s), int'(tbl[i].rd0));
            chk("tbl_ovf", int'(ov_s), int'(tbl[i].ov));
            chk("tbl_udf", int'(un_s), int'(tbl[i].un));
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill to full, then one write too many.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_afull", int'(af_s), int'(i + 1 >= 14));
        end
        chk("fill_full", int'(full_s), 1);
        chk("fill_count", int'(count_s), 16);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("extra_wr_ovf", int'(ov_s), 1);
        chk("extra_wr_count", int'(count_s), 16);

        // Drain all sixteen, then one read too many.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_rdata", int'(rd_s), i);
            chk("drain_valid", int'(valid_s), 1);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("extra_rd_udf", int'(un_s), 1);
        chk("extra_rd_valid", int'(valid_s), 0);
        chk("extra_rd_count", int'(count_s), 0);

        // Concurrent write/read at count 5 keeps count and order.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'(8'h20 + i), 1'b1);
            chk("wr_rd_count", int'(count_s), 5);
            chk("wr_rd_order", int'(rd_s), 8'h10 + i);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Write and read together while full: read wins, write dropped.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full_wr_rd_count", int'(count_s), 15);
        chk("full_wr_rd_ovf", int'(ov_s), 1);
        chk("full_wr_rd_rdata", int'(rd_s), 8'h40);

        // Flush with seven entries, raised flags and a concurrent write.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_flush_count", int'(count_s), 7);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_count", int'(count_s), 0);
        chk("flush_empty", int'(empty_s), 1);
        chk("flush_udf", int'(un_s), 0);
        chk("flush_ovf", int'(ov_s), 0);
        chk("flush_valid_f", int'(valid_f), 0);

        // FWFT: word written to empty FIFO appears without rd_en.
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("fwft_valid", int'(valid_f), 1);
        chk("fwft_rdata", int'(rd_f), 8'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_hold", int'(rd_f), 8'h5A);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_pop_valid", int'(valid_f), 0);

        // Forty words through the FWFT head, wrapping the pointers.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        rd_idx = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 10; i < 40; i++) begin
            chk("wrap_data", int'(rd_f), 8'h30 + rd_idx);
            step(1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
            rd_idx++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("wrap_data", int'(rd_f), 8'h30 + rd_idx);
            step(1'b0, 1'b0, 8'h00, 1'b1);
            rd_idx++;
        end
        chk("wrap_empty", int'(empty_f), 1);

        // Async reset asserted mid-cycle during a write burst.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h98 + i), 1'b0);
        wr_en   = 1'b1;
        wr_data = 8'hBB;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", int'(count_s), 0);
        chk("async_rst_empty", int'(empty_f), 1);
        chk("async_rst_valid_f", int'(valid_f), 0);
        check_model();
        @(posedge clk);
        #1;
        chk("held_rst_count", int'(count_s), 0);
        wr_en = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomised traffic in phases biased toward full, empty and balanced.
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            for (int c = 0; c < 400; c++) begin
                step($urandom_range(0, 99) == 0,
                     $urandom_range(0, 99) < wp,
                     8'($urandom),
                     $urandom_range(0, 99) < rp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
